// File: rtl/debounce_fsm_pkg.sv
// Shared state encoding and default parameters for the switch debouncer.
package debounce_fsm_pkg;

    localparam int DEFAULT_STABLE_TICKS = 3;
    localparam int DEFAULT_SYNC_STAGES  = 2;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_e;

    // Committed level seen by the outside world while in a given state.
    function automatic logic state_level(input db_state_e s);
        return (s == ONE) || (s == WAIT0);
    endfunction

endpackage

// File: rtl/debounce_fsm_sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input; latency STAGES clk.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[STAGES-2:0], d};
        end
    end

    assign q = sr_q[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Debounces one raw switch into a clean level plus 1-clk rise/fall pulses.
// Latency: SYNC_STAGES clk plus (STABLE_TICKS-1..STABLE_TICKS) tick periods; no backpressure.
module debounce_fsm
    import debounce_fsm_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic db_lvl,
    output logic db_rise,
    output logic db_fall
);

    localparam int                CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             btn_s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A disagreeing btn_s aborts the window even on a tick cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (btn_s) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!btn_s) begin
                    state_d = ZERO;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ONE;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ONE: begin
                if (!btn_s) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (btn_s) begin
                    state_d = ONE;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ZERO;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
        lvl_d = state_level(state_d);
    end

    assign db_lvl  = lvl_q;
    assign db_rise = rise_q;
    assign db_fall = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm: directed scenarios with literal timing plus randomized traffic vs a reference model.
module tb_debounce_fsm;

    localparam int ST   = 3;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic reset;
    logic tick = 1'b0;
    logic btn_in;
    logic db_lvl, db_rise, db_fall;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    debounce_fsm #(.STABLE_TICKS(ST), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .btn_in  (btn_in),
        .db_lvl  (db_lvl),
        .db_rise (db_rise),
        .db_fall (db_fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick is sampled high at every edge whose index is a multiple of 10.
    always @(negedge clk) tick = ((cyc % 10) == 9);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the committed level flips once btn_s has disagreed with it
    // for ST ticks, not counting a tick on the very first disagreeing cycle.
    int hist [SYNC];
    bit m_lvl = 0, m_pend = 0, m_started = 0;
    bit e_rise = 0, e_fall = 0;
    int m_cnt = 0;

    always @(posedge clk) begin
        bit bs;
        if (!reset) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 0;
            m_lvl = 0; m_pend = 0; m_cnt = 0; e_rise = 0; e_fall = 0;
            m_started = 1;
        end else begin
            bs = hist[0][0];
            for (int i = 0; i < SYNC - 1; i++) hist[i] = hist[i+1];
            hist[SYNC-1] = int'(btn_in);
            e_rise = 0; e_fall = 0;
            if (bs == m_lvl) begin
                m_pend = 0; m_cnt = 0;
            end else if (!m_pend) begin
                m_pend = 1; m_cnt = 0;
            end else if (tick) begin
                m_cnt++;
                if (m_cnt == ST) begin
                    m_lvl  = ~m_lvl;
                    m_pend = 0;
                    e_rise = m_lvl;
                    e_fall = !m_lvl;
                end
            end
        end
    end

    bit prev_pulse = 0;
    always @(negedge clk) begin
        if (m_started) begin
            check("model_lvl",  int'(db_lvl),  int'(m_lvl));
            check("model_rise", int'(db_rise), int'(e_rise));
            check("model_fall", int'(db_fall), int'(e_fall));
            check("rise_and_fall", int'(db_rise & db_fall), 0);
            check("pulse_2_cycles", int'(prev_pulse & (db_rise | db_fall)), 0);
            prev_pulse = db_rise | db_fall;
            if (db_rise) rise_cnt++;
            if (db_fall) fall_cnt++;
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic align();
        do @(negedge clk); while ((cyc % 10) != 0);
    endtask

    task automatic wait_lvl(input string name, input logic v, input int budget, output int at);
        bit found = 0;
        at = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (db_lvl == v) begin
                found = 1;
                at = cyc;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: db_lvl never reached %0d within %0d clk", name, v, budget);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int start, at;
        reset  = 1'b0;
        btn_in = 1'b1;

        // T1: reset held with the button high.
        repeat (3) begin
            @(negedge clk);
            check("t1_outputs_in_reset", int'({db_lvl, db_rise, db_fall}), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("t1_outputs_after_release", int'({db_lvl, db_rise, db_fall}), 0);
        btn_in = 1'b0;
        do_reset(2);
        repeat (5) @(negedge clk);

        // T2: clean press commits on the third counted tick.
        align();
        btn_in = 1'b1; start = cyc; rise_cnt = 0;
        wait_lvl("t2", 1'b1, 60, at);
        check("t2_latency", at - start, 30);
        check("t2_rise_with_lvl", int'(db_rise), 1);
        repeat (20) @(negedge clk);
        check("t2_rise_count", rise_cnt, 1);

        // T4: release.
        align();
        btn_in = 1'b0; start = cyc; rise_cnt = 0; fall_cnt = 0;
        wait_lvl("t4", 1'b0, 60, at);
        check("t4_latency", at - start, 30);
        check("t4_fall_with_lvl", int'(db_fall), 1);
        repeat (20) @(negedge clk);
        check("t4_fall_count", fall_cnt, 1);
        check("t4_rise_count", rise_cnt, 0);

        // T3: bounce after two counted ticks restarts the window.
        align();
        btn_in = 1'b1; start = cyc; rise_cnt = 0;
        wait_until(start + 21); btn_in = 1'b0;
        wait_until(start + 26); btn_in = 1'b1;
        wait_until(start + 31);
        check("t3_no_early_commit", int'(db_lvl), 0);
        check("t3_no_early_rise", rise_cnt, 0);
        wait_lvl("t3", 1'b1, 40, at);
        check("t3_latency", at - start, 50);
        btn_in = 1'b0;
        repeat (60) @(negedge clk);
        check("t3_released", int'(db_lvl), 0);

        // T5: btn_s drops on the same edge as the would-be committing tick.
        align();
        btn_in = 1'b1; start = cyc; rise_cnt = 0;
        wait_until(start + 27); btn_in = 1'b0;
        wait_until(start + 45);
        check("t5_lvl_stays_low", int'(db_lvl), 0);
        check("t5_no_rise", rise_cnt, 0);

        // T6: reset mid-window with the button held.
        align();
        btn_in = 1'b1; start = cyc; rise_cnt = 0; fall_cnt = 0;
        wait_until(start + 22); reset = 1'b0;
        wait_until(start + 25); reset = 1'b1;
        wait_lvl("t6", 1'b1, 60, at);
        check("t6_latency", at - start, 50);
        repeat (10) @(negedge clk);
        check("t6_rise_count", rise_cnt, 1);
        check("t6_fall_count", fall_cnt, 0);

        // Randomized holds and occasional resets, checked by the model every cycle.
        for (int n = 0; n < 150; n++) begin
            btn_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 45)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
